// File: rtl/det_ctrl.sv
// det_ctrl: collects three points A, B, C and forms the two diagonal product
// sums of their determinant using one time-shared XW x YW multiplier.
module det_ctrl #(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XW-1:0]      Ix,
  input  logic [YW-1:0]      Iy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XW+YW+1:0]   Op,
  output logic [XW+YW+1:0]   Os,
  output logic [XW+YW+2:0]   Det,
  output logic               det_neg,
  output logic [XW+YW+1:0]   det_abs,
  output logic               busy
);

  localparam int PW = XW + YW;
  localparam int AW = XW + YW + 2;
  localparam int DW = XW + YW + 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_SUB  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_r, next_state_s;
  logic [1:0]      idx_r;
  logic [2:0]      k_r;
  logic [XW-1:0]   ax_r, bx_r, cx_r, mx_s;
  logic [YW-1:0]   ay_r, by_r, cy_r, my_s;
  logic [PW-1:0]   prod_s, prod_r;
  logic [AW-1:0]   acc_p_r, acc_s_r, op_r, os_r, det_abs_r, det_mag_s;
  logic [DW-1:0]   det_r, det_s;
  logic            det_neg_r;
  logic            in_ready_s, out_valid_s, busy_s, accept_s, last_pt_s;

  assign accept_s  = in_valid & in_ready_s;
  assign last_pt_s = accept_s & (idx_r == 2'd2);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= next_state_s;
  end

  // next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE:  if (accept_s) next_state_s = S_LOAD; else next_state_s = S_IDLE;
      S_LOAD:  if (last_pt_s) next_state_s = S_MUL; else next_state_s = S_LOAD;
      S_MUL:   if (k_r == 3'd6) next_state_s = S_SUB; else next_state_s = S_MUL;
      S_SUB:   next_state_s = S_DONE;
      S_DONE:  if (out_ready) next_state_s = S_IDLE; else next_state_s = S_DONE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // handshake and status decode
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b1;
    case (state_r)
      S_IDLE:  begin in_ready_s = 1'b1; busy_s = 1'b0; end
      S_LOAD:  in_ready_s = 1'b1;
      S_DONE:  out_valid_s = 1'b1;
      default: begin in_ready_s = 1'b0; out_valid_s = 1'b0; end
    endcase
  end

  // k selects the operand pair; k=6 only drains the product register
  always_comb begin
    mx_s = {XW{1'b0}};
    my_s = {YW{1'b0}};
    case (k_r)
      3'd0:    begin mx_s = ax_r; my_s = by_r; end
      3'd1:    begin mx_s = bx_r; my_s = cy_r; end
      3'd2:    begin mx_s = cx_r; my_s = ay_r; end
      3'd3:    begin mx_s = cx_r; my_s = by_r; end
      3'd4:    begin mx_s = ax_r; my_s = cy_r; end
      3'd5:    begin mx_s = bx_r; my_s = ay_r; end
      default: begin mx_s = {XW{1'b0}}; my_s = {YW{1'b0}}; end
    endcase
  end

  assign prod_s    = {{YW{1'b0}}, mx_s} * {{XW{1'b0}}, my_s};
  assign det_s     = {1'b0, acc_p_r} - {1'b0, acc_s_r};
  assign det_mag_s = (acc_p_r >= acc_s_r) ? (acc_p_r - acc_s_r) : (acc_s_r - acc_p_r);

  // point capture, multiply-accumulate sequencing and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= 2'd0;   k_r <= 3'd0;
      ax_r <= {XW{1'b0}}; bx_r <= {XW{1'b0}}; cx_r <= {XW{1'b0}};
      ay_r <= {YW{1'b0}}; by_r <= {YW{1'b0}}; cy_r <= {YW{1'b0}};
      prod_r <= {PW{1'b0}};
      acc_p_r <= {AW{1'b0}}; acc_s_r <= {AW{1'b0}};
      op_r <= {AW{1'b0}}; os_r <= {AW{1'b0}}; det_abs_r <= {AW{1'b0}};
      det_r <= {DW{1'b0}}; det_neg_r <= 1'b0;
    end else begin
      if (accept_s) begin
        case (idx_r)
          2'd0:    begin ax_r <= Ix; ay_r <= Iy; end
          2'd1:    begin bx_r <= Ix; by_r <= Iy; end
          2'd2:    begin cx_r <= Ix; cy_r <= Iy; end
          default: begin end
        endcase
        idx_r <= (idx_r == 2'd2) ? 2'd0 : idx_r + 2'd1;
      end
      if (last_pt_s) begin
        acc_p_r <= {AW{1'b0}};
        acc_s_r <= {AW{1'b0}};
        k_r     <= 3'd0;
      end else if (state_r == S_MUL) begin
        k_r    <= k_r + 3'd1;
        prod_r <= prod_s;
        // product registered at step k lands in its accumulator at step k+1
        if (k_r >= 3'd1 && k_r <= 3'd3) acc_p_r <= acc_p_r + {2'b00, prod_r};
        else if (k_r >= 3'd4)          acc_s_r <= acc_s_r + {2'b00, prod_r};
      end
      if (state_r == S_SUB) begin
        op_r      <= acc_p_r;
        os_r      <= acc_s_r;
        det_r     <= det_s;
        det_neg_r <= det_s[DW-1];
        det_abs_r <= det_mag_s;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign busy      = busy_s;
  assign Op        = op_r;
  assign Os        = os_r;
  assign Det       = det_r;
  assign det_neg   = det_neg_r;
  assign det_abs   = det_abs_r;

endmodule

// File: tb/tb_det_ctrl.sv
// tb_det_ctrl: random and directed triples checked against diagonal sums
// computed directly from the point coordinates.
module tb_det_ctrl;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int AW = XW + YW + 2;
  localparam int DW = XW + YW + 3;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, det_neg, busy;
  logic [XW-1:0] Ix;
  logic [YW-1:0] Iy;
  logic [AW-1:0] Op, Os, det_abs;
  logic [DW-1:0] Det;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  det_ctrl #(.XW(XW), .YW(YW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Ix(Ix), .Iy(Iy), .out_valid(out_valid), .out_ready(out_ready),
    .Op(Op), .Os(Os), .Det(Det), .det_neg(det_neg), .det_abs(det_abs),
    .busy(busy)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_Op"}, Op, 0);
    check({tag, "_Os"}, Os, 0);
    check({tag, "_Det"}, Det, 0);
    check({tag, "_det_neg"}, det_neg, 0);
    check({tag, "_det_abs"}, det_abs, 0);
  endtask

  // pulse reset starting at a negedge, end at a negedge
  task automatic pulse_reset(input string tag);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_reset_state(tag);
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic send_point(input int x, input int y, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0; Ix = XW'($urandom); Iy = YW'($urandom);
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b1; Ix = x[XW-1:0]; Iy = y[YW-1:0];
    check("in_ready_load", in_ready, 1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_triple(input int ax, input int ay, input int bx, input int by,
                            input int cx, input int cy, input int gap, input int hold,
                            input string tag);
    longint p, s, d, ab;
    logic [63:0] d64;
    logic [DW-1:0] dexp;
    int lat;
    p = longint'(ax) * by + longint'(bx) * cy + longint'(cx) * ay;
    s = longint'(cx) * by + longint'(ax) * cy + longint'(bx) * ay;
    d = p - s;
    d64 = 64'(d);
    dexp = d64[DW-1:0];
    ab = (d < 0) ? -d : d;
    out_ready = (hold == 0);
    send_point(ax, ay, 0);
    send_point(bx, by, gap);
    send_point(cx, cy, gap);
    check({tag, "_no_early_valid"}, out_valid, 0);
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      in_valid = 1'b1; Ix = XW'($urandom); Iy = YW'($urandom);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_in_ready_low"}, in_ready, 0);
      @(posedge clk); @(negedge clk);
      if (out_valid) lat = n;
    end
    check({tag, "_latency"}, lat, 8);
    check({tag, "_Op"}, Op, p);
    check({tag, "_Os"}, Os, s);
    check({tag, "_Det"}, Det, dexp);
    check({tag, "_det_neg"}, det_neg, (d < 0) ? 1 : 0);
    check({tag, "_det_abs"}, det_abs, ab);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_Det"}, Det, dexp);
      check({tag, "_hold_Op"}, Op, p);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_drop_valid"}, out_valid, 0);
    check({tag, "_idle_in_ready"}, in_ready, 1);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_held_Det"}, Det, dexp);
    check({tag, "_held_Os"}, Os, s);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; Ix = '0; Iy = '0;
    @(negedge clk); @(negedge clk);
    check_reset_state("por");
    rst = 1'b0;
    @(negedge clk);
    check("por_in_ready", in_ready, 1);

    run_triple(0, 0, 4, 0, 0, 3, 0, 0, "pos12");
    run_triple(0, 0, 0, 3, 4, 0, 0, 1, "neg12");
    run_triple(1023, 0, 0, 511, 0, 0, 0, 0, "maxp");
    run_triple(1023, 511, 1023, 511, 1023, 511, 0, 2, "equal");
    run_triple(0, 0, 4, 0, 0, 3, 0, 5, "stall5");
    run_triple(0, 0, 0, 3, 4, 0, 0, 0, "after_stall");

    // reset after B discards the partial triple
    send_point(7, 9, 0);
    send_point(100, 200, 0);
    pulse_reset("rst_load");
    run_triple(0, 0, 4, 0, 0, 3, 0, 0, "rst_load_next");

    // reset during MUL and during DONE: no result may appear
    send_point(5, 6, 0); send_point(7, 8, 0); send_point(9, 10, 0);
    repeat (3) @(negedge clk);
    pulse_reset("rst_mul");
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_mul_no_valid", seen, 0);
    send_point(300, 100, 0); send_point(2, 400, 0); send_point(50, 3, 0);
    repeat (10) @(negedge clk);
    check("done_before_rst", out_valid, 1);
    pulse_reset("rst_done");
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_done_no_valid", seen, 0);

    run_triple(0, 0, 4, 0, 0, 3, 1, 0, "gapped");

    for (int t = 0; t < 40; t++) begin
      run_triple($urandom_range(0, 1023), $urandom_range(0, 511),
                 $urandom_range(0, 1023), $urandom_range(0, 511),
                 $urandom_range(0, 1023), $urandom_range(0, 511),
                 $urandom_range(0, 2), $urandom_range(0, 3), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/det_ctrl.md
DET_CTRL -- requirements
Module: det_ctrl

Interface
REQ-001 Parameter XW, default 10, X coordinate width (640-wide frame).
REQ-002 Parameter YW, default 9, Y coordinate width (480-high frame).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 in_valid  input  1  a point is presented on Ix/Iy.
REQ-006 in_ready  output  1  the block accepts a point this cycle.
REQ-007 Ix  input  XW  point X coordinate, unsigned.
REQ-008 Iy  input  YW  point Y coordinate, unsigned.
REQ-009 out_valid  output  1  the result fields are valid.
REQ-010 out_ready  input  1  the consumer takes the result.
REQ-011 Op  output  XW+YW+2  main-diagonal sum, unsigned.
REQ-012 Os  output  XW+YW+2  secondary-diagonal sum, unsigned.
REQ-013 Det  output  XW+YW+3  Op minus Os, two's complement.
REQ-014 det_neg  output  1  Det is negative.
REQ-015 det_abs  output  XW+YW+2  magnitude of Det.
REQ-016 busy  output  1  the FSM is in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, LOAD, MUL, SUB, DONE.
REQ-018 in_ready shall be 1 only in IDLE and LOAD; a point is accepted on any edge where in_valid and in_ready are both 1.
REQ-019 Accepted points go to A, B, C in arrival order via a 2-bit index; IDLE moves to LOAD on the first acceptance.
REQ-020 Acceptance of C moves LOAD to MUL, clears both accumulators, and sets step k=0; gaps in in_valid during LOAD stall without losing stored points.
REQ-021 MUL uses exactly one shared XW x YW unsigned multiplier, one product per cycle, for k=0..5.
- k=0 Ax*By, k=1 Bx*Cy, k=2 Cx*Ay: added into accP.
- k=3 Cx*By, k=4 Ax*Cy, k=5 Bx*Ay: added into accS.
REQ-022 After k=5, MUL moves to SUB; SUB registers Op=accP, Os=accS, Det=accP-accS (sign-extended), det_neg=Det MSB, det_abs=|Det|; then DONE.
REQ-023 Accumulators are XW+YW+2 bits wide; no overflow is possible (3*(2^XW-1)*(2^YW-1) < 2^(XW+YW+2)).
REQ-024 out_valid shall be 1 exactly in DONE; result outputs stay stable while out_valid=1 and out_ready=0.
REQ-025 DONE with out_ready=1 returns to IDLE; out_valid drops on the next cycle; result outputs hold their last values.
REQ-026 Latency: out_valid rises on the 8th rising edge after the edge that accepts C (6 MUL + 1 SUB + 1 register).
REQ-027 in_ready is 0 throughout MUL, SUB, and DONE; no new triple starts until the result is consumed.
REQ-028 Equal diagonals give Det=0, det_neg=0, det_abs=0.
REQ-029 busy=1 in LOAD, MUL, SUB, and DONE.

Reset
REQ-030 While rst=1: FSM=IDLE; index, k, accP, accS, A, B, C, Op, Os, Det, det_abs all 0; det_neg, out_valid, busy all 0; in_ready=1 after release.
REQ-031 rst asserted mid-LOAD, MUL, or DONE shall discard partial points and any pending result; no out_valid follows.
REQ-032 The first point accepted after reset is always stored as A.

Verification
REQ-033 A=(0,0), B=(4,0), C=(0,3), out_ready=1 -> Op=12, Os=0, Det=12, det_neg=0, det_abs=12; out_valid 8 edges after C.
REQ-034 A=(0,0), B=(0,3), C=(4,0) -> Op=0, Os=12, Det=-12 (all-ones pattern minus 11), det_neg=1, det_abs=12.
REQ-035 A=(1023,0), B=(0,511), C=(0,0) -> Op=522753, Os=0, Det=522753; repeat with A=(1023,511), B=(1023,511), C=(1023,511) -> Op=Os=1568259, Det=0.
REQ-036 out_ready held 0 for 5 cycles in DONE -> out_valid and outputs stable, in_ready=0; on release, IDLE next cycle, and the next triple is accepted.
REQ-037 rst pulsed after B is accepted, then triple (0,0), (4,0), (0,3) -> Det=12; no spurious out_valid before it.
REQ-038 in_valid toggling 1-0-1-0-1 during LOAD -> exactly three points are captured, and the results match REQ-033.
